dram_port_arbiter: RTL
======================

// Module: dram_port_arbiter
// PURPOSE
//  Shares the single-port word-addressed data RAM between instruction fetch (IF, read-only)
//  and load/store unit (LSU, read/write) of the NPC core. Both sides use valid/ready request
//  and response channels; the block converts each accepted request into one mem_ren or
//  mem_wen pulse, buffers the registered read data and returns it to the owner.
//  One transaction outstanding at a time.
// PARAMETERS
//  ADDR_W  32  byte-address width of requester ports
//  DATA_W  32  data width (mask is DATA_W/8 bits, fixed 4 at default)
//  IDX_W   30  RAM word-index width; mem_*addr = addr[IDX_W+1:2]
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       synchronous active-low reset
//  if_req_valid    in   1       IF read request
//  if_req_ready    out  1       IF request accepted this cycle
//  if_addr         in   ADDR_W  IF byte address
//  if_resp_valid   out  1       IF read data valid
//  if_resp_ready   in   1       IF consumes response
//  if_rdata        out  DATA_W  IF read data
//  lsu_req_valid   in   1       LSU request
//  lsu_req_ready   out  1       LSU request accepted
//  lsu_we          in   1       1 = write, 0 = read
//  lsu_addr        in   ADDR_W  LSU byte address
//  lsu_wdata       in   DATA_W  write data
//  lsu_wmask       in   4       byte enables
//  lsu_resp_valid  out  1       LSU response (read data or write ack)
//  lsu_resp_ready  in   1       LSU consumes response
//  lsu_rdata       out  DATA_W  LSU read data (0 for write ack)
//  mem_ren/mem_raddr  out 1/IDX_W   RAM read strobe / word index
//  mem_rdata          in  DATA_W    RAM data, registered, valid 1 cycle after mem_ren
//  mem_wen/mem_waddr/mem_wdata/mem_wmask  out 1/IDX_W/DATA_W/4  RAM write port
// BEHAVIOUR
//  - Reset: state IDLE, owner=LSU, all *_ready/*_valid/mem_ren/mem_wen = 0, rdata regs = 0.
//    Reset mid-transaction drops it; no response is ever issued for it.
//  - FSM IDLE -> RD_WAIT -> RESP -> IDLE (read); IDLE -> RESP -> IDLE (write).
//  - IDLE: grant chosen combinationally from valids; granted *_req_ready=1 same cycle
//    (ready depends on valid); other ready=0. Fire = valid & ready.
//    Read fire: mem_ren=1, mem_raddr=addr[IDX_W+1:2] in fire cycle -> RD_WAIT.
//    Write fire: mem_wen=1, waddr/wdata/wmask driven in fire cycle -> RESP (ack, rdata=0).
//  - RD_WAIT: capture mem_rdata into resp buffer -> RESP. mem_ren=0.
//  - RESP: owner's *_resp_valid=1, data stable until *_resp_ready; on handshake -> IDLE.
//    Non-owner resp_valid always 0. Both req_ready=0 outside IDLE (no back-to-back issue).
//  - Latency: read fire T -> resp_valid T+2; write fire T -> ack T+1; next accept at
//    earliest cycle after response handshake.
//  - Arbitration, both valid in IDLE: LSU wins (fixed priority) unless RR feature on.
//  - mem_ren and mem_wen never both 1; both 0 except in fire cycle.
//  - Requesters hold valid/addr/data stable until ready; arbiter does not re-check after fire.
//  - addr[1:0] ignored (word access); no misalignment error.
// CONFIGURATION
//  DRAM_ARB_RR_EN defined: round-robin; 1-bit last_grant flips to the granted side on each
//    fire; on conflict the side not last granted wins. Reset last_grant=LSU (IF wins first).
//  Undefined: fixed priority LSU > IF; last_grant logic absent.
// TESTING
//  1. IF read 0x0000_0010, RAM word[4]=0xDEAD_BEEF -> mem_ren T, mem_raddr=4,
//     if_resp_valid T+2, if_rdata=0xDEAD_BEEF.
//  2. LSU write 0x8, wdata=0x1122_3344, wmask=4'b0011 -> mem_wen=1 one cycle, waddr=2,
//     wmask=0011; lsu_resp_valid T+1, rdata=0; readback = old[31:16],0x3344.
//  3. Both valid in IDLE, no RR -> LSU granted, if_req_ready=0; IF granted after LSU resp.
//  4. DRAM_ARB_RR_EN, both valid continuously 4 transactions -> grants IF,LSU,IF,LSU.
//  5. Read resp held with if_resp_ready=0 for 5 cycles -> if_resp_valid/rdata stable,
//     both req_ready=0; accept resumes cycle after ready.
//  6. rst_n=0 in RD_WAIT -> next cycle all outputs 0, state IDLE, no resp_valid afterwards.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares a single-port word RAM between instruction fetch (read-only) and the LSU.
// Define DRAM_ARB_RR_EN for round-robin arbitration; the default build uses fixed LSU > IF priority.
module dram_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_ren,
  output logic [IDX_W-1:0]  mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [IDX_W-1:0]  mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner_lsu;
  logic              r_if_resp_valid;
  logic              r_lsu_resp_valid;
  logic [DATA_W-1:0] r_rdata;

  logic              w_idle;
  logic              w_prefer_lsu;
  logic              w_gnt_lsu;
  logic              w_gnt_if;
  logic              w_lsu_fire;
  logic              w_if_fire;
  logic              w_lsu_rd_fire;
  logic              w_resp_hs;
  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_lsu_idx;
  logic              w_unused_addr;

  // Word access only: the byte offset and any bits above the RAM index are dropped.
  assign w_if_idx      = if_addr[IDX_W+1:2];
  assign w_lsu_idx     = lsu_addr[IDX_W+1:2];
  assign w_unused_addr = ^{if_addr, lsu_addr};

`ifdef DRAM_ARB_RR_EN
  logic r_last_lsu;

  // On a conflict the side that was not granted last time wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_lsu <= 1'b1;
    end else if (w_lsu_fire) begin
      r_last_lsu <= 1'b1;
    end else if (w_if_fire) begin
      r_last_lsu <= 1'b0;
    end
  end

  assign w_prefer_lsu = ~r_last_lsu;
`else
  assign w_prefer_lsu = 1'b1;
`endif

  // Grant is decided combinationally from the valids while idle.
  always_comb begin
    w_idle        = rst_n && (r_state == S_IDLE);
    w_gnt_lsu     = lsu_req_valid && (!if_req_valid || w_prefer_lsu);
    w_gnt_if      = if_req_valid && !w_gnt_lsu;
    w_lsu_fire    = w_idle && w_gnt_lsu;
    w_if_fire     = w_idle && w_gnt_if;
    w_lsu_rd_fire = w_lsu_fire && !lsu_we;
    w_resp_hs     = (r_if_resp_valid && if_resp_ready) || (r_lsu_resp_valid && lsu_resp_ready);
  end

  assign if_req_ready  = w_if_fire;
  assign lsu_req_ready = w_lsu_fire;

  assign mem_ren   = w_if_fire || w_lsu_rd_fire;
  assign mem_raddr = w_if_fire ? w_if_idx : (w_lsu_rd_fire ? w_lsu_idx : '0);
  assign mem_wen   = w_lsu_fire && lsu_we;
  assign mem_waddr = mem_wen ? w_lsu_idx : '0;
  assign mem_wdata = mem_wen ? lsu_wdata : '0;
  assign mem_wmask = mem_wen ? lsu_wmask : 4'b0000;

  assign if_resp_valid  = r_if_resp_valid;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign if_rdata       = r_rdata;
  assign lsu_rdata      = r_rdata;

  // Transaction FSM with registered response channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_owner_lsu      <= 1'b1;
      r_if_resp_valid  <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_rdata          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_lsu_fire) begin
            r_owner_lsu <= 1'b1;
            if (lsu_we) begin
              r_rdata          <= '0;
              r_lsu_resp_valid <= 1'b1;
              r_state          <= S_RESP;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end else if (w_if_fire) begin
            r_owner_lsu <= 1'b0;
            r_state     <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          r_rdata          <= mem_rdata;
          r_if_resp_valid  <= !r_owner_lsu;
          r_lsu_resp_valid <= r_owner_lsu;
          r_state          <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_if_resp_valid  <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
